tetris_line_clear: RTL and testbench

//  After a piece locks, scans the playfield RAM bottom-to-top, removes every full row and

---
 rtl/tetris_pkg.sv | 22 ++
 rtl/tetris_line_clear.sv | 147 ++++++++++++++
 tb/tb_tetris_line_clear.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared playfield constants and the line-clear FSM state type.
package tetris_pkg;

  localparam int FIELD_WIDTH     = 10;
  localparam int FIELD_HEIGHT    = 20;
  localparam int ROW_ADDR_W      = $clog2(FIELD_HEIGHT);
  localparam int MAX_CLEAR_LINES = 4;
  localparam int LINES_CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FILL,
    REPORT
  } line_clear_state_t;

  // The score table only has entries for 0..MAX_CLEAR_LINES cleared rows.
  function automatic logic [LINES_CNT_W-1:0] clamp_lines(input int unsigned cnt);
    return (cnt > MAX_CLEAR_LINES) ? LINES_CNT_W'(MAX_CLEAR_LINES) : LINES_CNT_W'(cnt);
  endfunction

endpackage

// File: rtl/tetris_line_clear.sv
// Removes full rows from the playfield RAM in one bottom-to-top pass, compacting the
// survivors downward and zero-filling the top, then reports how many rows vanished.
module tetris_line_clear #(
  parameter int FIELD_WIDTH  = tetris_pkg::FIELD_WIDTH,
  parameter int FIELD_HEIGHT = tetris_pkg::FIELD_HEIGHT,
  parameter int ROW_ADDR_W   = $clog2(FIELD_HEIGHT)
) (
  input  logic                   clk,
  input  logic                   srst_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   row_rd_en_o,
  output logic [ROW_ADDR_W-1:0]  row_rd_addr_o,
  input  logic [FIELD_WIDTH-1:0] row_rd_data_i,
  output logic                   row_wr_en_o,
  output logic [ROW_ADDR_W-1:0]  row_wr_addr_o,
  output logic [FIELD_WIDTH-1:0] row_wr_data_o,
  output logic [2:0]             disappear_lines_cnt_o,
  output logic                   update_stat_en_o
);
  import tetris_pkg::*;

  localparam int CNT_W = ROW_ADDR_W + 1;

  line_clear_state_t state_q, state_d;

  logic [CNT_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [ROW_ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [ROW_ADDR_W-1:0]  rd_row_q, rd_row_d;
  logic                   wr_en_q, wr_en_d;
  logic [ROW_ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [FIELD_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [2:0]             lines_cnt_q, lines_cnt_d;

  logic rd_issue;
  logic row_full;
  logic last_row;

  always_comb begin
    rd_issue = (state_q == SCAN) && (rd_ptr_q < CNT_W'(FIELD_HEIGHT));
    row_full = &row_rd_data_i;
    last_row = rd_valid_q && (rd_row_q == ROW_ADDR_W'(FIELD_HEIGHT - 1));
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SCAN;
      SCAN:    if (last_row) state_d = (cnt_d != '0) ? FILL : REPORT;
      FILL:    if (wr_ptr_q == ROW_ADDR_W'(FIELD_HEIGHT - 1)) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data returns one cycle late, so the row index travels alongside in rd_row_q;
  // the write pointer therefore never overtakes the row currently being read.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    rd_valid_d  = rd_issue;
    rd_row_d    = rd_ptr_q[ROW_ADDR_W-1:0];
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    lines_cnt_d = lines_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end
      SCAN: begin
        if (rd_issue) rd_ptr_d = rd_ptr_q + CNT_W'(1);
        if (rd_valid_q) begin
          if (row_full) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            wr_data_d = row_rd_data_i;
            wr_ptr_d  = wr_ptr_q + ROW_ADDR_W'(1);
          end
        end
      end
      FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr_q;
        wr_data_d = '0;
        wr_ptr_d  = wr_ptr_q + ROW_ADDR_W'(1);
      end
      default: ;
    endcase
    if ((state_d == REPORT) && (state_q != REPORT)) lines_cnt_d = clamp_lines(int'(cnt_d));
  end

  always_ff @(posedge clk) begin
    if (srst_i) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_row_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      lines_cnt_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      rd_valid_q  <= rd_valid_d;
      rd_row_q    <= rd_row_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      lines_cnt_q <= lines_cnt_d;
    end
  end

  always_comb begin
    busy_o                = (state_q != IDLE);
    done_o                = (state_q == REPORT);
    update_stat_en_o      = (state_q == REPORT);
    row_rd_en_o           = rd_issue;
    row_rd_addr_o         = rd_issue ? rd_ptr_q[ROW_ADDR_W-1:0] : '0;
    row_wr_en_o           = wr_en_q;
    row_wr_addr_o         = wr_addr_q;
    row_wr_data_o         = wr_data_q;
    disappear_lines_cnt_o = lines_cnt_q;
  end

endmodule

// File: tb/tb_tetris_line_clear.sv
// Scoreboard bench for tetris_line_clear: directed playfields go in with their
// hand-derived results queued; a monitor checks each done pulse and the final RAM.
module tb_tetris_line_clear;
  import tetris_pkg::*;

  localparam int W  = FIELD_WIDTH;
  localparam int H  = FIELD_HEIGHT;
  localparam int AW = ROW_ADDR_W;

  typedef logic [H-1:0][W-1:0] field_t;

  typedef struct {
    logic [2:0] cnt;
    int         latency;
    field_t     rows;
    int         start_cycle;
    int         id;
  } exp_t;

  logic          clk = 1'b0;
  logic          srst_i;
  logic          start_i;
  logic          busy_o;
  logic          done_o;
  logic          row_rd_en_o;
  logic [AW-1:0] row_rd_addr_o;
  logic [W-1:0]  rd_data;
  logic          row_wr_en_o;
  logic [AW-1:0] row_wr_addr_o;
  logic [W-1:0]  row_wr_data_o;
  logic [2:0]    disappear_lines_cnt_o;
  logic          update_stat_en_o;

  int vectors     = 0;
  int miscompares = 0;
  int pulse_count = 0;
  int cycle       = 0;

  exp_t   sb_q[$];
  exp_t   mon_item;
  logic [W-1:0] mem [H];
  field_t load_field;
  logic   load_req = 1'b0;

  tetris_line_clear dut (
    .clk                   (clk),
    .srst_i                (srst_i),
    .start_i               (start_i),
    .busy_o                (busy_o),
    .done_o                (done_o),
    .row_rd_en_o           (row_rd_en_o),
    .row_rd_addr_o         (row_rd_addr_o),
    .row_rd_data_i         (rd_data),
    .row_wr_en_o           (row_wr_en_o),
    .row_wr_addr_o         (row_wr_addr_o),
    .row_wr_data_o         (row_wr_data_o),
    .disappear_lines_cnt_o (disappear_lines_cnt_o),
    .update_stat_en_o      (update_stat_en_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Row RAM with one-cycle read latency; a same-row read and write would be a hazard.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < H; i++) mem[i] <= load_field[i];
    end else if (row_wr_en_o) begin
      mem[row_wr_addr_o] <= row_wr_data_o;
    end
    if (row_rd_en_o) rd_data <= mem[row_rd_addr_o];
    if (row_rd_en_o && row_wr_en_o && (row_rd_addr_o == row_wr_addr_o)) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL rw_hazard: got read and write of row %0d together, expected disjoint rows", row_rd_addr_o);
    end
  end

  function automatic logic [W-1:0] pat(input int i);
    return W'((i * 73 + 11) % 1023);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic loadField(input field_t f);
    @(negedge clk);
    load_field = f;
    load_req   = 1'b1;
    @(negedge clk);
    load_req   = 1'b0;
  endtask

  task automatic applyStimulus(input field_t init, input field_t exp_field, input int n_clear, input int id);
    exp_t item;
    loadField(init);
    item.cnt         = (n_clear > 4) ? 3'd4 : 3'(n_clear);
    item.latency     = H + 2 + n_clear;
    item.rows        = exp_field;
    item.start_cycle = cycle;
    item.id          = id;
    sb_q.push_back(item);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while ((sb_q.size() != 0 || busy_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL pass_timeout: got busy after %0d cycles, expected idle", n);
    end
    repeat (3) @(negedge clk);
  endtask

  // Monitor: every done pulse is matched against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (update_stat_en_o !== done_o) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL stat_vs_done: got update %0b with done %0b, expected equal", update_stat_en_o, done_o);
      end
      if (done_o === 1'b1) begin
        pulse_count++;
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_done: got pulse at cycle %0d, expected none", cycle);
        end else begin
          mon_item = sb_q.pop_front();
          checkOutput($sformatf("t%0d_lines_cnt", mon_item.id), 32'(disappear_lines_cnt_o), 32'(mon_item.cnt));
          checkOutput($sformatf("t%0d_busy_in_report", mon_item.id), 32'(busy_o), 32'd1);
          checkOutput($sformatf("t%0d_latency", mon_item.id), cycle - mon_item.start_cycle, mon_item.latency);
          @(posedge clk);
          @(negedge clk);
          checkOutput($sformatf("t%0d_done_one_cycle", mon_item.id), 32'(done_o), 32'd0);
          checkOutput($sformatf("t%0d_lines_cnt_held", mon_item.id), 32'(disappear_lines_cnt_o), 32'(mon_item.cnt));
          for (int r = 0; r < H; r++) begin
            checkOutput($sformatf("t%0d_row%0d", mon_item.id, r), 32'(mem[r]), 32'(mon_item.rows[r]));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish by 200us, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    field_t f_init;
    field_t f_exp;
    int     keep [16] = '{1, 3, 4, 6, 8, 9, 10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
    int     n;
    int     p;

    srst_i  = 1'b1;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_rd_en", 32'(row_rd_en_o), 32'd0);
    checkOutput("rst_wr_en", 32'(row_wr_en_o), 32'd0);
    checkOutput("rst_wr_addr", 32'(row_wr_addr_o), 32'd0);
    checkOutput("rst_wr_data", 32'(row_wr_data_o), 32'd0);
    checkOutput("rst_lines_cnt", 32'(disappear_lines_cnt_o), 32'd0);
    srst_i = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: empty field");
    f_init = '0;
    f_exp  = '0;
    applyStimulus(f_init, f_exp, 0, 1);
    waitDone(100);

    $display("[TB] test 2: bottom row full");
    f_init    = '0;
    f_exp     = '0;
    f_init[0] = '1;
    for (int i = 1; i < H; i++) f_init[i] = pat(i);
    for (int i = 1; i < H; i++) f_exp[i-1] = pat(i);
    applyStimulus(f_init, f_exp, 1, 2);
    waitDone(100);

    $display("[TB] test 3: rows 0,2,5,7 full");
    f_init = '0;
    f_exp  = '0;
    for (int i = 0; i < H; i++) f_init[i] = pat(i);
    f_init[0] = '1;
    f_init[2] = '1;
    f_init[5] = '1;
    f_init[7] = '1;
    for (int k = 0; k < 16; k++) f_exp[k] = pat(keep[k]);
    applyStimulus(f_init, f_exp, 4, 3);
    waitDone(100);

    $display("[TB] test 4: every row full");
    f_init = '1;
    f_exp  = '0;
    applyStimulus(f_init, f_exp, 20, 4);
    waitDone(150);

    $display("[TB] test 5: start during scan and during report");
    f_init    = '0;
    f_exp     = '0;
    f_init[0] = '1;
    for (int i = 1; i < H; i++) f_init[i] = pat(i);
    for (int i = 1; i < H; i++) f_exp[i-1] = pat(i);
    applyStimulus(f_init, f_exp, 1, 5);
    repeat (5) @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    checkOutput("t5_busy_during_scan", 32'(busy_o), 32'd1);
    n = 0;
    while (done_o !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL t5_done_timeout: got no pulse in %0d cycles, expected one", n);
    end else begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      checkOutput("t5_idle_after_report_start", 32'(busy_o), 32'd0);
    end
    waitDone(100);
    repeat (30) @(negedge clk);

    $display("[TB] test 6: reset in the middle of scan");
    loadField(f_init);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    p = pulse_count;
    srst_i = 1'b1;
    @(negedge clk);
    srst_i = 1'b0;
    checkOutput("t6_busy_after_srst", 32'(busy_o), 32'd0);
    checkOutput("t6_done_after_srst", 32'(done_o), 32'd0);
    checkOutput("t6_rd_en_after_srst", 32'(row_rd_en_o), 32'd0);
    checkOutput("t6_wr_en_after_srst", 32'(row_wr_en_o), 32'd0);
    repeat (40) @(negedge clk);
    checkOutput("t6_no_pulse_after_srst", pulse_count, p);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    checkOutput("total_pulses", pulse_count, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
